// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: ALU op codes, mux encodings, opcodes and
// register indices used by both the datapath and its controller.
package mips_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_srcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_JUMP   = 2'b01,
        PCSRC_ALUOUT = 2'b10,
        PCSRC_REGA   = 2'b11
    } pc_src_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [REG_AW-1:0] REG_RA = 5'd31;

    function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// register 0 hardwired to zero, all entries cleared by async reset.
module mips_regfile
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [XLEN-1:0]   o_rdata1_c,
    output logic [XLEN-1:0]   o_rdata2_c,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata
);

    logic [XLEN-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // No write bypass: a same-cycle write is seen only after the edge.
    assign o_rdata1_c = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2_c = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/mips_mc_datapath.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut, inline ALU and muxes,
// register file sub-module. Sequencing comes from an external controller.
module mips_mc_datapath
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            PCWriteCond,
    input  logic            IorD,
    input  logic            MemWrite,
    input  logic            MemRead,
    input  logic            IRWrite,
    input  logic            RegDst,
    input  logic            WriteRegSel,
    input  logic            MemtoReg,
    input  logic            WriteDataSel,
    input  logic            RegWrite,
    input  logic            ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [1:0]      PCSrc,
    input  logic [2:0]      ALUoperation,
    output logic            zeroflag,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            mem_read,
    output logic            mem_write
);

    logic [XLEN-1:0]   r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;
    logic [XLEN-1:0]   w_rd1, w_rd2;
    logic [XLEN-1:0]   w_alu_a, w_alu_b, w_alu_result;
    logic [XLEN-1:0]   w_imm_sext, w_wdata, w_pc_next;
    logic [REG_AW-1:0] w_wreg;
    logic [5:0]        w_opcode;
    logic              w_branch_taken, w_pc_en;

    assign w_opcode   = r_ir[31:26];
    assign w_imm_sext = sign_ext16(r_ir[15:0]);
    assign w_alu_a    = ALUSrcA ? r_a : r_pc;

    always_comb begin
        w_alu_b = r_b;
        case (ALUSrcB)
            SRCB_REG:     w_alu_b = r_b;
            SRCB_FOUR:    w_alu_b = XLEN'(4);
            SRCB_IMM:     w_alu_b = w_imm_sext;
            SRCB_IMM_SH2: w_alu_b = {w_imm_sext[XLEN-3:0], 2'b00};
            default:      w_alu_b = r_b;
        endcase
    end

    // Unlisted operation codes deliberately produce zero.
    always_comb begin
        w_alu_result = '0;
        case (ALUoperation)
            ALU_AND: w_alu_result = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_result = w_alu_a | w_alu_b;
            ALU_ADD: w_alu_result = w_alu_a + w_alu_b;
            ALU_SUB: w_alu_result = w_alu_a - w_alu_b;
            ALU_SLT: w_alu_result = XLEN'($signed(w_alu_a) < $signed(w_alu_b));
            default: w_alu_result = '0;
        endcase
    end

    assign zeroflag = (w_alu_result == '0);

    always_comb begin
        w_branch_taken = 1'b0;
        if (w_opcode == OP_BEQ) begin
            w_branch_taken = zeroflag;
        end else if (w_opcode == OP_BNE) begin
            w_branch_taken = !zeroflag;
        end
    end

    always_comb begin
        w_wreg = r_ir[20:16];
        if (WriteRegSel) begin
            w_wreg = REG_RA;
        end else if (RegDst) begin
            w_wreg = r_ir[20:16];
        end else if (w_opcode == OP_RTYPE) begin
            w_wreg = r_ir[15:11];
        end
    end

    // Link writes take the PC before this edge's update.
    assign w_wdata = WriteDataSel ? r_pc : (MemtoReg ? r_mdr : r_aluout);

    always_comb begin
        w_pc_next = w_alu_result;
        case (PCSrc)
            PCSRC_ALU:    w_pc_next = w_alu_result;
            PCSRC_JUMP:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
            PCSRC_ALUOUT: w_pc_next = r_aluout;
            PCSRC_REGA:   w_pc_next = r_a;
            default:      w_pc_next = w_alu_result;
        endcase
    end

    assign w_pc_en = PCWrite | (PCWriteCond & w_branch_taken);

    mips_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_raddr1   (r_ir[25:21]),
        .i_raddr2   (r_ir[20:16]),
        .o_rdata1_c (w_rd1),
        .o_rdata2_c (w_rd2),
        .i_we       (RegWrite),
        .i_waddr    (w_wreg),
        .i_wdata    (w_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
            if (IRWrite) begin
                r_ir <= mem_rdata;
            end
            r_mdr    <= mem_rdata;
            r_a      <= w_rd1;
            r_b      <= w_rd2;
            r_aluout <= w_alu_result;
        end
    end

    assign instruction = r_ir;
    assign mem_addr    = IorD ? r_aluout : r_pc;
    assign mem_wdata   = r_b;
    assign mem_read    = MemRead;
    assign mem_write   = MemWrite;

endmodule

// File: doc/mips_mc_datapath.md
MIPS_MC_DATAPATH -- requirements
Module: mips_mc_datapath

Interface
REQ-001 SHALL have ports: clk, in, 1, clock; all state updates on its rising edge.
REQ-002 SHALL have ports: rst, in, 1, reset, asynchronous, active-high.
REQ-003 SHALL have control inputs, all 1-bit: PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA.
REQ-004 SHALL have control inputs ALUSrcB (2-bit), PCSrc (2-bit) and ALUoperation (3-bit).
REQ-005 SHALL have outputs zeroflag (1-bit, ALU result == 0) and instruction (32-bit, the IR contents).
REQ-006 SHALL have memory port signals: mem_addr (out, 32), mem_wdata (out, 32), mem_rdata (in, 32, combinational read), mem_read (out, 1), mem_write (out, 1).

Function
REQ-007 SHALL hold architectural registers PC, IR, MDR, A, B and ALUOut, all 32-bit, plus a 32x32 register file.
REQ-008 SHALL drive mem_addr = IorD ? ALUOut : PC; mem_wdata = B; mem_read = MemRead; mem_write = MemWrite, all combinational.
REQ-009 SHALL load IR from mem_rdata only when IRWrite=1 at the clock edge.
REQ-010 SHALL load MDR, A (= rf[IR[25:21]]), B (= rf[IR[20:16]]) and ALUOut (= ALU result) unconditionally on every clock edge.
REQ-011 SHALL select ALU input A as PC when ALUSrcA=0 and as register A when ALUSrcA=1.
REQ-012 SHALL select ALU input B by ALUSrcB: 00 = B; 01 = 32'd4; 10 = sign-extended IR[15:0]; 11 = sign-extended IR[15:0] shifted left by 2.
REQ-013 SHALL decode ALUoperation as: 000 = AND; 001 = OR; 010 = ADD (mod 2^32); 110 = SUB (mod 2^32); 111 = signed SLT returning 1 or 0; any other code returns 0.
REQ-014 SHALL drive zeroflag combinationally from the current ALU result, not from ALUOut.
REQ-015 SHALL select the write register as 31 when WriteRegSel=1, else IR[20:16] when RegDst=1, else IR[15:11] if IR[31:26]==0, else IR[20:16].
REQ-016 SHALL select write data as PC when WriteDataSel=1, else MDR when MemtoReg=1, else ALUOut.
REQ-017 SHALL write the register file on the clock edge when RegWrite=1; a write to register 0 SHALL be ignored and register 0 SHALL always read 0.
REQ-018 SHALL read the register file combinationally; a same-cycle write SHALL become visible only after the clock edge (no bypass).
REQ-019 SHALL compute the next PC by PCSrc: 00 = ALU result; 01 = {PC[31:28], IR[25:0], 2'b00}; 10 = ALUOut; 11 = register A.
REQ-020 SHALL compute branch_taken as zeroflag when IR[31:26]=000100 (beq), as !zeroflag when IR[31:26]=000101 (bne), and 0 otherwise.
REQ-021 SHALL load PC on the clock edge when PCWrite | (PCWriteCond & branch_taken).
REQ-022 SHALL, when PCWrite and RegWrite/WriteDataSel are asserted in the same cycle, write the pre-update PC value to the register file (jal link).
REQ-023 SHALL give every register exactly one-cycle latency from its enable to the updated value; no other internal state or stalls SHALL exist.

Reset
REQ-024 SHALL clear PC, IR, MDR, A, B, ALUOut and all 32 register-file entries to 0 immediately when rst asserts, independent of clk.
REQ-025 SHALL make the first instruction fetch after reset release use address 0.
REQ-026 SHALL, on a reset asserted mid-instruction, discard any pending write with no partial register or PC update.

Structure
REQ-027 SHALL take the ALUoperation codes, ALUSrcB/PCSrc encodings, opcode constants (R-type, beq, bne) and register 31 index from the shared mips_pkg used by the controller.
REQ-028 SHALL place the register file in a sub-module mips_regfile with 2 read ports, 1 write port and async reset; the ALU, extenders and muxes SHALL stay inline.

Verification
REQ-029 SHALL verify fetch: after reset, mem_rdata=0x20080005 with IRWrite=1, ALUSrcB=01, ALUoperation=010, PCWrite=1 -> instruction=0x20080005 and PC=4 one edge later.
REQ-030 SHALL verify addi: with IR=0x20080005 and rf[0]=0, a RTstart-style cycle (ALUSrcA=1, ALUSrcB=10, op 010) followed by RegWrite=1 -> rf[8]=5, and rf[0] stays 0.
REQ-031 SHALL verify beq: with rf[1]=rf[2]=7, IR=0x10220003, PC=8 and ALUOut=8+12, then PCWriteCond=1, PCSrc=10, op 110 -> zeroflag=1 and PC=20; with rf[2]=6 -> PC stays 8.
REQ-032 SHALL verify lw/sw: sw with rf[9]=0x100, rf[10]=0xABCD, imm=4 -> mem_addr=0x104, mem_wdata=0xABCD, mem_write=1; lw of the same address with mem_rdata=0xABCD -> rt register=0xABCD.
REQ-033 SHALL verify jal/jr: PC=0x00400004, IR=0x0C000010, PCWrite=1, PCSrc=01, WriteRegSel=WriteDataSel=RegWrite=1 -> rf[31]=0x00400004 and PC=0x00000040; then jr $31 with PCSrc=11 -> PC=0x00400004.
REQ-034 SHALL verify slt and async reset: rf[1]=-1 and rf[2]=1 with op 111 -> ALUOut=1; asserting rst mid-cycle -> PC, IR and rf[1] read 0 before the next clk edge.
